wwvb_pulse_decoder: RTL and testbench
=====================================

Name: wwvb_pulse_decoder

Overview:
Downstream consumer of the CIC decimator output stream. It slices the decimated carrier-amplitude samples into a high/low level using hysteresis. It then measures the duration of each reduced-power (low) interval in samples and classifies it as a WWVB ZERO (0.2 s), ONE (0.5 s), MARKER (0.8 s) or ERROR. Symbols and their measured lengths are emitted on a valid/ready output for the frame assembler and the serializer path.

Parameters:
DATA_WIDTH, 13, width of the decimated sample input (unsigned)
CNT_WIDTH, 12, width of the pulse-length counter; saturates at 2^CNT_WIDTH-1
THRESH_HI, 3000, sample >= this forces level high
THRESH_LO, 1000, sample <= this forces level low; must be < THRESH_HI
ZERO_MIN, 150 / ZERO_MAX, 250, low-length window (samples, inclusive) for ZERO
ONE_MIN, 450 / ONE_MAX, 550, window for ONE
MARK_MIN, 750 / MARK_MAX, 850, window for MARKER
TIMEOUT, 1500, run length (either level) at which ERROR is emitted without an edge

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-low reset
input_tdata  in  DATA_WIDTH  decimated sample
input_tvalid  in  1  sample valid
input_tready  out  1  = !output_tvalid || output_tready
output_tdata  out  2  symbol code: 0 ZERO, 1 ONE, 2 MARKER, 3 ERROR
output_tlen  out  CNT_WIDTH  measured run length belonging to the symbol
output_tvalid  out  1  symbol valid
output_tready  in  1  consumer ready
level  out  1  current sliced level (debug/LED)

Behaviour:
- Reset (rst=0, async): state=HIGH, level=1, cnt=0, err_sent=0, output_tvalid=0, output_tdata=0, output_tlen=0.
- Beat accepted = input_tvalid && input_tready. State, counters and level change only on accepted beats.
- Slicer, combinational on an accepted beat: lvl_n = 1 if tdata>=THRESH_HI; 0 if tdata<=THRESH_LO; otherwise the current level.
- FSM states: HIGH, LOW.
  - HIGH and lvl_n=0: go to LOW, cnt=1, err_sent=0.
  - HIGH and lvl_n=1: cnt=sat(cnt+1).
  - LOW and lvl_n=0: cnt=sat(cnt+1).
  - LOW and lvl_n=1: classify cnt; emit symbol unless err_sent; go to HIGH, cnt=1, err_sent=0.
- Classification, on the pre-increment low length L:
  - ZERO_MIN<=L<=ZERO_MAX gives 0.
  - ONE window gives 1.
  - MARK window gives 2.
  - Any other value gives 3. output_tlen=L.
- Timeout: in either state, when the updated cnt equals TIMEOUT and err_sent=0, emit ERROR with tlen=TIMEOUT and set err_sent=1. Exactly one ERROR per run. The later edge of that run emits nothing.
- Counter saturates at all-ones and never wraps.
- Latency: output_tvalid rises on the clock edge that consumes the edge-causing beat (1 cycle after the beat is presented).
- Output register is single-entry. It holds data stable while tvalid && !tready.
- input_tready drops during that output stall, so no symbol is ever lost or overwritten.
- Simultaneous output handshake and new symbol in the same cycle: the register reloads and tvalid stays 1.
- Handshake-only cycle: tvalid clears.
- Mid-operation reset clears everything immediately; a pending symbol is discarded.
- Samples between the thresholds never cause a transition (hysteresis).

Decomposition:
- Package wwvb_pkg holds:
  - symbol code constants (SYM_ZERO/ONE/MARK/ERR)
  - FSM state encoding
  - window defaults, shared with the frame assembler
- Natural sub-module: wwvb_level_slicer, the hysteresis comparator plus level register, enabled by beat-accept.

Test Plan:
1. Reset, then 100 samples of 4000, 200 of 0, then 4000 -> one symbol 0, tlen=200; level follows.
2. Low runs of 500 and 800 samples, each separated by 300 high samples -> symbols 1 (tlen 500) then 2 (tlen 800).
3. Low run of 350 -> symbol 3, tlen 350. Low run of 150 and of 250 -> symbol 0 (inclusive boundaries). Run of 149 -> symbol 3.
4. Low, then 2000 low samples, then high -> exactly one ERROR with tlen=1500 at the 1500th low sample, no symbol on the rising edge. Same check for 2000 high samples.
5. Samples alternate 2000/2500 while level=1 -> no transition. Then 900 -> level=0.
6. Hold output_tready=0 when a symbol is pending -> input_tready=0, symbol held stable. Release -> handshake completes and input resumes. Assert rst mid-LOW -> all outputs return to reset values.

Source files
------------

// File: rtl/wwvb_pkg.sv
//==== wwvb_pkg : WWVB symbol codes, decoder FSM encoding, window defaults ====
//==== rev 1.0 ================================================================
`default_nettype none

package wwvb_pkg;

  localparam logic [1:0] SYM_ZERO = 2'd0;
  localparam logic [1:0] SYM_ONE  = 2'd1;
  localparam logic [1:0] SYM_MARK = 2'd2;
  localparam logic [1:0] SYM_ERR  = 2'd3;

  typedef enum logic [0:0] {
    ST_HIGH = 1'b0,
    ST_LOW  = 1'b1
  } state_t;

  // Windows in decimated samples; the frame assembler reuses these.
  localparam int THRESH_HI_DEF = 3000;
  localparam int THRESH_LO_DEF = 1000;
  localparam int ZERO_MIN_DEF  = 150;
  localparam int ZERO_MAX_DEF  = 250;
  localparam int ONE_MIN_DEF   = 450;
  localparam int ONE_MAX_DEF   = 550;
  localparam int MARK_MIN_DEF  = 750;
  localparam int MARK_MAX_DEF  = 850;
  localparam int TIMEOUT_DEF   = 1500;

endpackage

`default_nettype wire

// File: rtl/wwvb_level_slicer.sv
//==== wwvb_level_slicer : hysteresis comparator with level register ========
//==== rev 1.0 ================================================================
`default_nettype none

module wwvb_level_slicer
  import wwvb_pkg::*;
#(
  parameter int DATA_WIDTH = 13,
  parameter int THRESH_HI  = THRESH_HI_DEF,
  parameter int THRESH_LO  = THRESH_LO_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic [DATA_WIDTH-1:0] sample,
  output logic                  lvl_n,
  output logic                  level
);

  localparam logic [DATA_WIDTH-1:0] c_hi = DATA_WIDTH'(THRESH_HI);
  localparam logic [DATA_WIDTH-1:0] c_lo = DATA_WIDTH'(THRESH_LO);

  // Between the thresholds the previous level is kept.
  always_comb begin
    lvl_n = level;
    if (sample >= c_hi) begin
      lvl_n = 1'b1;
    end else if (sample <= c_lo) begin
      lvl_n = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      level <= 1'b1;
    end else if (en) begin
      level <= lvl_n;
    end
  end

endmodule

`default_nettype wire

// File: rtl/wwvb_pulse_decoder.sv
//==== wwvb_pulse_decoder : low-pulse length classifier for WWVB symbols ====
//==== rev 1.0 ================================================================
`default_nettype none

module wwvb_pulse_decoder
  import wwvb_pkg::*;
#(
  parameter int DATA_WIDTH = 13,
  parameter int CNT_WIDTH  = 12,
  parameter int THRESH_HI  = THRESH_HI_DEF,
  parameter int THRESH_LO  = THRESH_LO_DEF,
  parameter int ZERO_MIN   = ZERO_MIN_DEF,
  parameter int ZERO_MAX   = ZERO_MAX_DEF,
  parameter int ONE_MIN    = ONE_MIN_DEF,
  parameter int ONE_MAX    = ONE_MAX_DEF,
  parameter int MARK_MIN   = MARK_MIN_DEF,
  parameter int MARK_MAX   = MARK_MAX_DEF,
  parameter int TIMEOUT    = TIMEOUT_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] input_tdata,
  input  logic                  input_tvalid,
  output logic                  input_tready,
  output logic [1:0]            output_tdata,
  output logic [CNT_WIDTH-1:0]  output_tlen,
  output logic                  output_tvalid,
  input  logic                  output_tready,
  output logic                  level
);

  localparam logic [CNT_WIDTH-1:0] c_one     = CNT_WIDTH'(1);
  localparam logic [CNT_WIDTH-1:0] c_max     = {CNT_WIDTH{1'b1}};
  localparam logic [CNT_WIDTH-1:0] c_timeout = CNT_WIDTH'(TIMEOUT);
  localparam logic [CNT_WIDTH-1:0] c_zmin    = CNT_WIDTH'(ZERO_MIN);
  localparam logic [CNT_WIDTH-1:0] c_zmax    = CNT_WIDTH'(ZERO_MAX);
  localparam logic [CNT_WIDTH-1:0] c_omin    = CNT_WIDTH'(ONE_MIN);
  localparam logic [CNT_WIDTH-1:0] c_omax    = CNT_WIDTH'(ONE_MAX);
  localparam logic [CNT_WIDTH-1:0] c_mmin    = CNT_WIDTH'(MARK_MIN);
  localparam logic [CNT_WIDTH-1:0] c_mmax    = CNT_WIDTH'(MARK_MAX);

  state_t               r_state, w_state_n;
  logic [CNT_WIDTH-1:0] r_cnt, w_cnt_n, w_cnt_inc, w_len;
  logic                 r_err_sent, w_err_n;
  logic                 w_accept, w_lvl_n, w_emit;
  logic [1:0]           w_sym, w_class;

  assign input_tready = !output_tvalid || output_tready;
  assign w_accept     = input_tvalid && input_tready;
  assign w_cnt_inc    = (r_cnt == c_max) ? r_cnt : r_cnt + c_one;

  wwvb_level_slicer #(
    .DATA_WIDTH (DATA_WIDTH),
    .THRESH_HI  (THRESH_HI),
    .THRESH_LO  (THRESH_LO)
  ) u_slicer (
    .clk    (clk),
    .rst    (rst),
    .en     (w_accept),
    .sample (input_tdata),
    .lvl_n  (w_lvl_n),
    .level  (level)
  );

  always_comb begin
    w_class = SYM_ERR;
    if (r_cnt >= c_zmin && r_cnt <= c_zmax) begin
      w_class = SYM_ZERO;
    end else if (r_cnt >= c_omin && r_cnt <= c_omax) begin
      w_class = SYM_ONE;
    end else if (r_cnt >= c_mmin && r_cnt <= c_mmax) begin
      w_class = SYM_MARK;
    end
  end

  always_comb begin
    w_state_n = r_state;
    w_cnt_n   = r_cnt;
    w_err_n   = r_err_sent;
    w_emit    = 1'b0;
    w_sym     = SYM_ZERO;
    w_len     = '0;
    if (w_accept) begin
      if (w_lvl_n != (r_state == ST_HIGH)) begin
        // Level flipped: a falling edge opens a run, a rising edge closes it.
        w_state_n = (r_state == ST_HIGH) ? ST_LOW : ST_HIGH;
        w_cnt_n   = c_one;
        w_err_n   = 1'b0;
        if (r_state == ST_LOW && !r_err_sent) begin
          w_emit = 1'b1;
          w_sym  = w_class;
          w_len  = r_cnt;
        end
      end else begin
        w_cnt_n = w_cnt_inc;
        if (w_cnt_inc == c_timeout && !r_err_sent) begin
          w_emit  = 1'b1;
          w_sym   = SYM_ERR;
          w_len   = c_timeout;
          w_err_n = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= ST_HIGH;
      r_cnt      <= '0;
      r_err_sent <= 1'b0;
    end else begin
      r_state    <= w_state_n;
      r_cnt      <= w_cnt_n;
      r_err_sent <= w_err_n;
    end
  end

  // A symbol is only produced on an accepted beat, which implies the slot is free or draining.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      output_tvalid <= 1'b0;
      output_tdata  <= SYM_ZERO;
      output_tlen   <= '0;
    end else if (w_emit) begin
      output_tvalid <= 1'b1;
      output_tdata  <= w_sym;
      output_tlen   <= w_len;
    end else if (output_tready) begin
      output_tvalid <= 1'b0;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_wwvb_pulse_decoder.sv
//==== tb_wwvb_pulse_decoder : self-checking bench for wwvb_pulse_decoder ===
//==== rev 1.0 ================================================================
`default_nettype none

module tb_wwvb_pulse_decoder;
  import wwvb_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic [12:0] input_tdata;
  logic        input_tvalid;
  logic        input_tready;
  logic [1:0]  output_tdata;
  logic [11:0] output_tlen;
  logic        output_tvalid;
  logic        output_tready;
  logic        level;

  int checks = 0;
  int passed = 0;

  typedef struct {
    int         low;
    int         high;
    logic [1:0] sym;
  } vec_t;

  typedef struct {
    logic [1:0] sym;
    int         len;
  } exp_t;

  vec_t vecs[11];
  exp_t sb[$];
  exp_t e;

  wwvb_pulse_decoder dut (
    .clk           (clk),
    .rst           (rst),
    .input_tdata   (input_tdata),
    .input_tvalid  (input_tvalid),
    .input_tready  (input_tready),
    .output_tdata  (output_tdata),
    .output_tlen   (output_tlen),
    .output_tvalid (output_tvalid),
    .output_tready (output_tready),
    .level         (level)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d, required %0d (t=%0t)", name, act, exp, $time);
  endtask

  always @(negedge clk) begin
    if (rst && output_tvalid && output_tready) begin
      if (sb.size() == 0) begin
        checks++;
        $display("FAIL unexpected_symbol: got sym=%0d len=%0d, required none (t=%0t)",
                 output_tdata, output_tlen, $time);
      end else begin
        e = sb.pop_front();
        check("sym", int'(output_tdata), int'(e.sym));
        check("tlen", int'(output_tlen), e.len);
      end
    end
  end

  task automatic send(input int s);
    int guard = 0;
    input_tdata  = 13'(s);
    input_tvalid = 1'b1;
    @(negedge clk);
    while (!input_tready && guard < 1000) begin
      guard++;
      @(negedge clk);
    end
    if (guard >= 1000) begin
      checks++;
      $display("FAIL input_stall_timeout: got input_tready=0 for %0d cycles, required 1", guard);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic low_run(input int nlow, input int nhigh, input logic [1:0] sym);
    send(0);
    check("level_falls", int'(level), 0);
    for (int i = 1; i < nlow; i++) send(0);
    sb.push_back('{sym, nlow});
    send(4000);
    check("level_rises", int'(level), 1);
    check("symbol_latency", int'(output_tvalid), 1);
    for (int i = 1; i < nhigh; i++) send(4000);
  endtask

  task automatic do_reset();
    input_tvalid = 1'b0;
    rst = 1'b0;
    #1;
    check("rst_tvalid", int'(output_tvalid), 0);
    check("rst_tdata", int'(output_tdata), 0);
    check("rst_tlen", int'(output_tlen), 0);
    check("rst_level", int'(level), 1);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got no end of test, required $finish before 5 ms");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0]  = '{200, 300, SYM_ZERO};
    vecs[1]  = '{500, 300, SYM_ONE};
    vecs[2]  = '{800, 300, SYM_MARK};
    vecs[3]  = '{350, 300, SYM_ERR};
    vecs[4]  = '{150, 300, SYM_ZERO};
    vecs[5]  = '{250, 300, SYM_ZERO};
    vecs[6]  = '{149, 300, SYM_ERR};
    vecs[7]  = '{251, 300, SYM_ERR};
    vecs[8]  = '{449, 300, SYM_ERR};
    vecs[9]  = '{550, 300, SYM_ONE};
    vecs[10] = '{851, 300, SYM_ERR};

    rst           = 1'b1;
    input_tdata   = '0;
    input_tvalid  = 1'b0;
    output_tready = 1'b1;
    @(posedge clk);
    #1;
    do_reset();
    check("rst_input_tready", int'(input_tready), 1);

    for (int i = 0; i < 100; i++) send(4000);
    check("level_initial_high", int'(level), 1);
    for (int i = 0; i < 11; i++) low_run(vecs[i].low, vecs[i].high, vecs[i].sym);

    // Low timeout: one ERROR at the 1500th low sample, silent rising edge.
    for (int i = 0; i < 1499; i++) send(0);
    sb.push_back('{SYM_ERR, 1500});
    send(0);
    check("low_timeout_latency", int'(output_tvalid), 1);
    for (int i = 0; i < 500; i++) send(0);
    send(4000);
    check("no_sym_after_low_timeout", int'(output_tvalid), 0);
    // High timeout: the rising beat counts as the first high sample.
    for (int i = 0; i < 1498; i++) send(4000);
    sb.push_back('{SYM_ERR, 1500});
    send(4000);
    check("high_timeout_latency", int'(output_tvalid), 1);
    for (int i = 0; i < 500; i++) send(4000);
    low_run(200, 10, SYM_ZERO);

    // Hysteresis band holds either level.
    for (int i = 0; i < 20; i++) send((i % 2) ? 2500 : 2000);
    check("hyst_hold_high", int'(level), 1);
    send(900);
    check("below_lo_goes_low", int'(level), 0);
    for (int i = 0; i < 20; i++) send((i % 2) ? 2999 : 1001);
    check("hyst_hold_low", int'(level), 0);
    sb.push_back('{SYM_ERR, 21});
    send(3000);
    check("hi_boundary", int'(level), 1);
    send(1000);
    check("lo_boundary", int'(level), 0);
    sb.push_back('{SYM_ERR, 1});
    send(3000);
    for (int i = 0; i < 10; i++) send(4000);

    // Output stall back-pressures the input and holds the symbol.
    output_tready = 1'b0;
    low_run(200, 1, SYM_ZERO);
    input_tdata = 13'd4000;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("stall_input_tready", int'(input_tready), 0);
      check("stall_tlen_held", int'(output_tlen), 200);
    end
    check("stall_tdata_held", int'(output_tdata), int'(SYM_ZERO));
    @(posedge clk);
    #1;
    output_tready = 1'b1;
    for (int i = 0; i < 10; i++) send(4000);
    check("stall_released", int'(input_tready), 1);

    // Reset discards a pending symbol.
    output_tready = 1'b0;
    for (int i = 0; i < 200; i++) send(0);
    send(4000);
    check("pending_before_reset", int'(output_tvalid), 1);
    do_reset();
    output_tready = 1'b1;

    // Reset in the middle of a low run.
    for (int i = 0; i < 100; i++) send(0);
    check("mid_low_level", int'(level), 0);
    do_reset();
    for (int i = 0; i < 50; i++) send(4000);
    low_run(200, 10, SYM_ZERO);

    input_tvalid = 1'b0;
    repeat (5) @(negedge clk);
    check("scoreboard_empty", sb.size(), 0);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

`default_nettype wire
